dmem_rsel: RTL and testbench

- Load-side counterpart of the store write-select path.
- Registers the load request in the execute stage and selects the source one cycle later to match BRAM read latency: DMEM, BIOS, or memory-mapped IO.
- Extracts and sign/zero-extends the addressed byte or half.
- Owns the cycle and retired-instruction counters and the UART RX pop handshake.

---
 rtl/dmem_rsel.sv | 224 ++++++++++++++++++++++
 tb/tb_dmem_rsel.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_rsel.sv
// dmem_rsel -- load-side read select for the data memory path.
//
// Registers the execute-stage load request for one cycle so the result lines
// up with the BRAM read latency, then picks DMEM, BIOS or memory-mapped IO
// data. The addressed byte or half is sign- or zero-extended. The block also
// owns the cycle and retired-instruction counters and the UART RX pop strobe.
//
// Optional build macro: DMEM_RSEL_MISALIGN_EN
//   defined   -> load_misaligned flags misaligned LH/LHU/LW alongside rvalid
//   undefined -> load_misaligned is tied low and no detection logic exists
//
// Parameters:
//   CNT_WIDTH      width of both counters (<= 32, zero-extended on read)
//   UNMAPPED_DATA  word returned for unmapped or write-only addresses
//
// Ports:
//   clk, rst_n        core clock, synchronous active-low reset
//   addr, re, funct3  execute-stage load request
//   stall             pipeline hold (stage register and retire count freeze)
//   inst_retire       one instruction retired this cycle
//   counter_reset     clears both counters on the next edge
//   dmem_dout         DMEM read data, valid the cycle after addr
//   bios_dout         BIOS read data, valid the cycle after addr
//   uart_tx_ready     UART transmitter status
//   uart_rx_valid     UART receiver holds a byte
//   uart_rx_data      received byte
//   uart_rx_ready     pop strobe to the UART receiver (issue cycle)
//   rdata, rvalid     extended load result in the writeback stage
//   load_misaligned   misalignment flag (see macro above)

module dmem_rsel #(
  parameter int          CNT_WIDTH     = 32,
  parameter logic [31:0] UNMAPPED_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [2:0]  funct3,
  input  logic        stall,
  input  logic        inst_retire,
  input  logic        counter_reset,
  input  logic [31:0] dmem_dout,
  input  logic [31:0] bios_dout,
  input  logic        uart_tx_ready,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_ready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        load_misaligned
);

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  localparam logic [1:0] RG_DMEM = 2'd0;
  localparam logic [1:0] RG_BIOS = 2'd1;
  localparam logic [1:0] RG_IO   = 2'd2;
  localparam logic [1:0] RG_UNM  = 2'd3;

  localparam logic [3:0] IO_STATUS = 4'h0;
  localparam logic [3:0] IO_RXDATA = 4'h1;
  localparam logic [3:0] IO_CYCLE  = 4'h4;
  localparam logic [3:0] IO_INSTR  = 4'h5;

  // Upper offset bits inside a region do not affect selection.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[27:6];

  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] ins_q, ins_d;
  logic [31:0]          cyc_rd, ins_rd;

  logic        valid_q, valid_d;
  logic [1:0]  region_q, region_d;
  logic [1:0]  a_q, a_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] io_word_q, io_word_d;

  logic        issue;
  logic [7:0]  rx_byte;

  // ---------------- issue stage: decode and IO snapshot ----------------
  assign issue   = re & ~stall;
  assign rx_byte = uart_rx_valid ? uart_rx_data : 8'h00;

  always_comb begin
    cyc_rd = '0;
    ins_rd = '0;
    cyc_rd[CNT_WIDTH-1:0] = cyc_q;
    ins_rd[CNT_WIDTH-1:0] = ins_q;
  end

  always_comb begin
    case (addr[31:28])
      4'b0001: region_d = RG_DMEM;
      4'b0100: region_d = RG_BIOS;
      4'b1000: region_d = RG_IO;
      default: region_d = RG_UNM;
    endcase
  end

  // The IO word is captured at issue so the counters and RX byte form one
  // coherent snapshot even if the writeback cycle sees them move.
  always_comb begin
    case (addr[5:2])
      IO_STATUS: io_word_d = {30'b0, uart_rx_valid, uart_tx_ready};
      IO_RXDATA: io_word_d = {24'b0, rx_byte};
      IO_CYCLE:  io_word_d = cyc_rd;
      IO_INSTR:  io_word_d = ins_rd;
      default:   io_word_d = UNMAPPED_DATA;
    endcase
  end

  assign valid_d = re;
  assign a_d     = addr[1:0];
  assign f3_d    = funct3;

  // The pop and the byte capture happen on the same edge, so the receiver
  // is only told to advance when the stage register actually loads.
  assign uart_rx_ready = rst_n & issue & (region_d == RG_IO) &
                         (addr[5:2] == IO_RXDATA) & uart_rx_valid;

  // Clear wins over increment; the cycle counter ignores stall.
  always_comb begin
    cyc_d = cyc_q + CNT_WIDTH'(1);
    ins_d = ins_q;
    if (inst_retire && !stall) ins_d = ins_q + CNT_WIDTH'(1);
    if (counter_reset) begin
      cyc_d = '0;
      ins_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  // The cleared stage points at the IO word (also cleared) as an LW so the
  // combinational rdata reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      region_q  <= RG_IO;
      a_q       <= 2'b00;
      f3_q      <= FNC_LW;
      io_word_q <= '0;
    end else if (!stall) begin
      valid_q   <= valid_d;
      region_q  <= region_d;
      a_q       <= a_d;
      f3_q      <= f3_d;
      io_word_q <= io_word_d;
    end
  end

`ifdef DMEM_RSEL_MISALIGN_EN
  logic mis_q, mis_d;

  always_comb begin
    mis_d = 1'b0;
    if (re) begin
      if ((funct3 == FNC_LH || funct3 == FNC_LHU) && addr[0]) mis_d = 1'b1;
      if (funct3 == FNC_LW && addr[1:0] != 2'b00)              mis_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      mis_q <= 1'b0;
    else if (!stall) mis_q <= mis_d;
  end

  assign load_misaligned = mis_q;
`else
  assign load_misaligned = 1'b0;
`endif

  // ---------------- writeback stage: select and extend ----------------
  logic [31:0] word_sel;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (region_q)
      RG_DMEM: word_sel = dmem_dout;
      RG_BIOS: word_sel = bios_dout;
      RG_IO:   word_sel = io_word_q;
      default: word_sel = UNMAPPED_DATA;
    endcase
  end

  always_comb begin
    case (a_q)
      2'd0:    byte_sel = word_sel[7:0];
      2'd1:    byte_sel = word_sel[15:8];
      2'd2:    byte_sel = word_sel[23:16];
      default: byte_sel = word_sel[31:24];
    endcase
    half_sel = a_q[1] ? word_sel[31:16] : word_sel[15:0];
  end

  always_comb begin
    case (f3_q)
      FNC_LB:  rdata = {{24{byte_sel[7]}}, byte_sel};
      FNC_LBU: rdata = {24'b0, byte_sel};
      FNC_LH:  rdata = {{16{half_sel[15]}}, half_sel};
      FNC_LHU: rdata = {16'b0, half_sel};
      default: rdata = word_sel;
    endcase
  end

  assign rvalid = valid_q;

endmodule

// File: tb/tb_dmem_rsel.sv
module tb_dmem_rsel;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, re, stall, inst_retire, counter_reset;
  logic [31:0] addr, dmem_dout, bios_dout;
  logic [2:0]  funct3;
  logic        uart_tx_ready, uart_rx_valid;
  logic [7:0]  uart_rx_data;

  logic        rdy_a, rvalid_a, mis_a;
  logic [31:0] rdata_a;
  logic        rdy_b, rvalid_b, mis_b;
  logic [31:0] rdata_b;

  localparam logic [31:0] UNM_B = 32'hDEAD_BEEF;

  dmem_rsel u_a (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .funct3(funct3),
    .stall(stall), .inst_retire(inst_retire), .counter_reset(counter_reset),
    .dmem_dout(dmem_dout), .bios_dout(bios_dout),
    .uart_tx_ready(uart_tx_ready), .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data), .uart_rx_ready(rdy_a),
    .rdata(rdata_a), .rvalid(rvalid_a), .load_misaligned(mis_a)
  );

  dmem_rsel #(.CNT_WIDTH(4), .UNMAPPED_DATA(UNM_B)) u_b (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .funct3(funct3),
    .stall(stall), .inst_retire(inst_retire), .counter_reset(counter_reset),
    .dmem_dout(dmem_dout), .bios_dout(bios_dout),
    .uart_tx_ready(uart_tx_ready), .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data), .uart_rx_ready(rdy_b),
    .rdata(rdata_b), .rvalid(rvalid_b), .load_misaligned(mis_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: counters as plain integers, one pending load record.
  longint unsigned mcyc, mins;
  bit          p_valid, p_rst, p_mis;
  logic [31:0] p_addr, p_io_a, p_io_b;
  logic [2:0]  p_f3;

  function automatic logic [31:0] io_val(input logic [31:0] ad, input int w,
                                         input logic [31:0] unm);
    longint unsigned mask;
    int unsigned off;
    mask = (64'd1 << w) - 64'd1;
    off  = (ad >> 2) % 16;
    case (off)
      0:       return {30'b0, uart_rx_valid, uart_tx_ready};
      1:       return uart_rx_valid ? {24'b0, uart_rx_data} : 32'd0;
      4:       return 32'(mcyc & mask);
      5:       return 32'(mins & mask);
      default: return unm;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input int unsigned a,
                                          input logic [2:0] f3);
    int unsigned by, hf;
    by = (w >> (8 * a)) % 256;
    hf = (w >> (16 * (a / 2))) % 65536;
    case (f3)
      3'd0:    return (by >= 128) ? by - 256 : by;
      3'd4:    return by;
      3'd1:    return (hf >= 32768) ? hf - 65536 : hf;
      3'd5:    return hf;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] expect_rdata(input logic [31:0] io, input logic [31:0] unm);
    logic [31:0] w;
    case (p_addr >> 28)
      32'd1:   w = dmem_dout;
      32'd4:   w = bios_dout;
      32'd8:   w = io;
      default: w = unm;
    endcase
    return extract(w, p_addr % 4, p_f3);
  endfunction

  // One clock: check the pop strobe before the edge, advance the model at
  // the edge, then check the writeback outputs just after it.
  task automatic cyc();
    bit          exp_pop, nmis;
    logic [31:0] nio_a, nio_b;
    bit          exp_mis;
    #1;
    exp_pop = rst_n && re && !stall && (addr >> 28) == 8 &&
              ((addr >> 2) % 16) == 1 && uart_rx_valid;
    chk("pop_a", 32'(rdy_a), 32'(exp_pop));
    chk("pop_b", 32'(rdy_b), 32'(exp_pop));
    nio_a = io_val(addr, 32, 32'h0);
    nio_b = io_val(addr, 4, UNM_B);
    nmis  = re && (((funct3 == 3'd1 || funct3 == 3'd5) && (addr % 2) == 1) ||
                   (funct3 == 3'd2 && (addr % 4) != 0));
    @(posedge clk);
    if (!rst_n) begin
      p_valid = 0; p_rst = 1; p_mis = 0; mcyc = 0; mins = 0;
    end else begin
      if (!stall) begin
        p_valid = re; p_rst = 0; p_addr = addr; p_f3 = funct3;
        p_io_a = nio_a; p_io_b = nio_b; p_mis = nmis;
      end
      if (counter_reset) begin
        mcyc = 0; mins = 0;
      end else begin
        mcyc++;
        if (inst_retire && !stall) mins++;
      end
    end
    #1;
`ifdef DMEM_RSEL_MISALIGN_EN
    exp_mis = p_mis;
`else
    exp_mis = 0;
`endif
    chk("rvalid_a", 32'(rvalid_a), 32'(p_valid));
    chk("rvalid_b", 32'(rvalid_b), 32'(p_valid));
    chk("mis_a", 32'(mis_a), 32'(exp_mis));
    chk("mis_b", 32'(mis_b), 32'(exp_mis));
    if (p_rst) begin
      chk("rdata_rst_a", rdata_a, 32'h0);
      chk("rdata_rst_b", rdata_b, 32'h0);
    end else if (p_valid) begin
      chk("rdata_a", rdata_a, expect_rdata(p_io_a, 32'h0));
      chk("rdata_b", rdata_b, expect_rdata(p_io_b, UNM_B));
    end
  endtask

  task automatic idle_inputs();
    re = 0; stall = 0; inst_retire = 0; counter_reset = 0;
    addr = 32'h0; funct3 = 3'd2;
  endtask

  task automatic load(input logic [31:0] ad, input logic [2:0] f3);
    addr = ad; funct3 = f3; re = 1;
    cyc();
    re = 0;
  endtask

  typedef struct {
    logic [31:0] ad;
    logic [2:0]  f3;
    logic [31:0] dm;
    logic [31:0] bi;
    logic        txr;
    logic        rxv;
    logic [7:0]  rxd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{32'h1000_0003, 3'd0, 32'h80AA_BBCC, 32'h0, 1'b0, 1'b0, 8'h00, 32'hFFFF_FF80};
    vecs[1]  = '{32'h1000_0003, 3'd4, 32'h80AA_BBCC, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0000_0080};
    vecs[2]  = '{32'h4000_0002, 3'd1, 32'h0, 32'h8001_7FFF, 1'b0, 1'b0, 8'h00, 32'hFFFF_8001};
    vecs[3]  = '{32'h4000_0000, 3'd5, 32'h0, 32'h8001_7FFF, 1'b0, 1'b0, 8'h00, 32'h0000_7FFF};
    vecs[4]  = '{32'h8000_0004, 3'd2, 32'h0, 32'h0, 1'b0, 1'b1, 8'h5A, 32'h0000_005A};
    vecs[5]  = '{32'h2000_0000, 3'd2, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 8'h00, 32'h0000_0000};
    vecs[6]  = '{32'h1000_0001, 3'd1, 32'h1234_8765, 32'h0, 1'b0, 1'b0, 8'h00, 32'hFFFF_8765};
    vecs[7]  = '{32'h1000_0002, 3'd2, 32'hCAFE_BABE, 32'h0, 1'b0, 1'b0, 8'h00, 32'hCAFE_BABE};
    vecs[8]  = '{32'h1000_0000, 3'd3, 32'h89AB_CDEF, 32'h0, 1'b0, 1'b0, 8'h00, 32'h89AB_CDEF};
    vecs[9]  = '{32'h8000_0004, 3'd2, 32'h0, 32'h0, 1'b0, 1'b0, 8'h77, 32'h0000_0000};
    vecs[10] = '{32'h8000_0000, 3'd2, 32'h0, 32'h0, 1'b1, 1'b0, 8'h00, 32'h0000_0001};
    vecs[11] = '{32'h8000_0008, 3'd2, 32'h0, 32'h0, 1'b1, 1'b1, 8'h00, 32'h0000_0000};
    vecs[12] = '{32'h1000_0002, 3'd0, 32'h007F_0000, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0000_007F};
    vecs[13] = '{32'h4000_0003, 3'd5, 32'h0, 32'hFEDC_0000, 1'b0, 1'b0, 8'h00, 32'h0000_FEDC};

    idle_inputs();
    rst_n = 0; dmem_dout = 0; bios_dout = 0;
    uart_tx_ready = 0; uart_rx_valid = 0; uart_rx_data = 0;
    p_addr = 0; p_f3 = 0; p_io_a = 0; p_io_b = 0;
    mcyc = 0; mins = 0; p_valid = 0; p_rst = 1; p_mis = 0;
    @(posedge clk); #1;
    cyc(); cyc();
    chk("reset_rvalid", 32'(rvalid_a), 32'h0);
    chk("reset_rdata", rdata_a, 32'h0);

    // Counters: 10 cycles after reset, 4 retires.
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      inst_retire = (i < 4);
      cyc();
    end
    inst_retire = 0;
    load(32'h8000_0010, 3'd2);
    chk("cyc_after_10", rdata_a, 32'd10);
    load(32'h8000_0014, 3'd2);
    chk("ins_after_4", rdata_a, 32'd4);
    // Clear with a simultaneous retire and a cycle-counter read.
    counter_reset = 1; inst_retire = 1;
    load(32'h8000_0010, 3'd2);
    chk("cyc_pre_clear", rdata_a, 32'd12);
    counter_reset = 0; inst_retire = 0;
    load(32'h8000_0014, 3'd2);
    chk("ins_cleared", rdata_a, 32'd0);
    load(32'h8000_0010, 3'd2);
    chk("cyc_cleared", rdata_a, 32'd1);

    // Wrap of the 4-bit instance: 16 cycles after reset.
    rst_n = 0; cyc(); rst_n = 1;
    for (int i = 0; i < 16; i++) cyc();
    load(32'h8000_0010, 3'd2);
    chk("wrap_b", rdata_b, 32'd0);
    chk("nowrap_a", rdata_a, 32'd16);

    // Table of directed loads.
    for (int i = 0; i < 14; i++) begin
      dmem_dout = vecs[i].dm; bios_dout = vecs[i].bi;
      uart_tx_ready = vecs[i].txr; uart_rx_valid = vecs[i].rxv;
      uart_rx_data = vecs[i].rxd;
      load(vecs[i].ad, vecs[i].f3);
      chk($sformatf("vec%0d", i), rdata_a, vecs[i].exp);
    end
    cyc();

    // UART pop held off by stall, then released.
    uart_rx_valid = 1; uart_rx_data = 8'hA5;
    addr = 32'h8000_0004; funct3 = 3'd2; re = 1; stall = 1;
    cyc(); cyc();
    stall = 0;
    #1;
    chk("pop_after_stall", 32'(rdy_a), 32'h1);
    cyc();
    chk("rx_after_stall", rdata_a, 32'h0000_00A5);
    re = 0;
    cyc();

    // Misalignment cases.
    dmem_dout = 32'h0102_0304;
    load(32'h1000_0002, 3'd2);
    load(32'h1000_0002, 3'd1);
    load(32'h1000_0001, 3'd5);

    // Reset during an issue, and after an issue.
    load(32'h1000_0000, 3'd2);
    rst_n = 0;
    addr = 32'h8000_0004; re = 1; uart_rx_valid = 1;
    #1;
    chk("no_pop_in_reset", 32'(rdy_a), 32'h0);
    cyc();
    chk("rst_midload_rvalid", 32'(rvalid_a), 32'h0);
    rst_n = 1; re = 0;
    load(32'h2000_0000, 3'd2);
    chk("unmapped_a", rdata_a, 32'h0);
    chk("unmapped_b", rdata_b, UNM_B);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 3);
      case (r)
        0: addr = 32'h1000_0000;
        1: addr = 32'h4000_0000;
        2: addr = 32'h8000_0000;
        default: addr = 32'h2000_0000;
      endcase
      addr = addr | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3) |
             (($urandom % 1024) << 8);
      case ($urandom_range(0, 5))
        0: funct3 = 3'd0;
        1: funct3 = 3'd1;
        2: funct3 = 3'd2;
        3: funct3 = 3'd4;
        4: funct3 = 3'd5;
        default: funct3 = 3'd3;
      endcase
      re            = ($urandom % 3) != 0;
      stall         = ($urandom % 4) == 0;
      inst_retire   = $urandom % 2;
      counter_reset = ($urandom % 20) == 0;
      rst_n         = ($urandom % 50) != 0;
      dmem_dout     = $urandom;
      bios_dout     = $urandom;
      uart_tx_ready = $urandom % 2;
      uart_rx_valid = $urandom % 2;
      uart_rx_data  = 8'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
